// File: rtl/writeback_unit.sv
// writeback_unit: arbitrates ALU/LSU results into a FIFO, drives register-file writes and tracks pending registers
module writeback_unit #(
    parameter int DATA_BITS     = 8,
    parameter int FIFO_DEPTH    = 4,
    parameter int WRITABLE_REGS = 13
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 alu_valid,
    input  logic [3:0]           alu_rd,
    input  logic [DATA_BITS-1:0] alu_data,
    output logic                 alu_ready,
    input  logic                 lsu_valid,
    input  logic [3:0]           lsu_rd,
    input  logic [DATA_BITS-1:0] lsu_data,
    output logic                 lsu_ready,
    input  logic                 reserve_valid,
    input  logic [3:0]           reserve_rd,
    output logic                 wr_en,
    output logic [3:0]           wr_addr,
    output logic [DATA_BITS-1:0] wr_data,
    output logic [15:0]          pending,
    output logic                 busy,
    output logic                 ro_violation,
    output logic                 waw_error
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_BITS+3:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        head, tail;
    logic [AW:0]          count;
    logic                 rr_alu;
    logic                 full, empty, accept, acc_ro, push, pop, res_ok;
    logic [3:0]           acc_rd;
    logic [DATA_BITS-1:0] acc_data;
    logic [15:0]          set_mask, clr_mask;

    // grant, read-only filter and scoreboard masks; readies are held low while in reset
    always_comb begin
        full      = count == (AW+1)'(FIFO_DEPTH);
        empty     = count == '0;
        alu_ready = reset & ~full & alu_valid & (~lsu_valid | rr_alu);
        lsu_ready = reset & ~full & lsu_valid & (~alu_valid | ~rr_alu);
        accept    = alu_ready | lsu_ready;
        acc_rd    = alu_ready ? alu_rd : lsu_rd;
        acc_data  = alu_ready ? alu_data : lsu_data;
        acc_ro    = 32'(acc_rd) >= WRITABLE_REGS;
        push      = accept & ~acc_ro;
        pop       = ~empty;
        res_ok    = reserve_valid & (32'(reserve_rd) < WRITABLE_REGS);
        set_mask  = res_ok ? 16'(1) << reserve_rd : '0;
        clr_mask  = wr_en ? 16'(1) << wr_addr : '0;
        busy      = ~empty | wr_en;
    end

    // FIFO pointers, occupancy and the round-robin pointer (moves only on contested grants)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head   <= '0;
            tail   <= '0;
            count  <= '0;
            rr_alu <= 1'b0;
        end else begin
            if (push) tail <= tail + AW'(1);
            if (pop) head <= head + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
            if (alu_valid & lsu_valid & ~full) rr_alu <= ~rr_alu;
        end
    end

    // FIFO storage needs no reset: occupancy alone decides what is valid
    always_ff @(posedge clk) begin
        if (push) mem[tail] <= {acc_rd, acc_data};
    end

    // registered write port, loaded from the FIFO head on every pop
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= pop;
            if (pop) {wr_addr, wr_data} <= mem[head];
        end
    end

    // pending scoreboard (set beats clear) and sticky error flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending      <= '0;
            ro_violation <= 1'b0;
            waw_error    <= 1'b0;
        end else begin
            pending      <= (pending & ~clr_mask) | set_mask;
            ro_violation <= ro_violation | (accept & acc_ro);
            waw_error    <= waw_error | (res_ok & pending[reserve_rd]);
        end
    end
endmodule

// File: tb/tb_writeback_unit.sv
// tb_writeback_unit: table vectors, hand sequences and random traffic checked against a queue-based model
module tb_writeback_unit;
    localparam int DEPTH = 4;
    localparam int WR    = 13;

    logic       clk = 1'b0, reset = 1'b0;
    logic       alu_valid, lsu_valid, reserve_valid;
    logic [3:0] alu_rd, lsu_rd, reserve_rd;
    logic [7:0] alu_data, lsu_data;
    logic       alu_ready, lsu_ready, wr_en, busy, ro_violation, waw_error;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic [15:0] pending;

    always #5 clk = ~clk;

    writeback_unit #(.DATA_BITS(8), .FIFO_DEPTH(DEPTH), .WRITABLE_REGS(WR)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
        .reserve_valid(reserve_valid), .reserve_rd(reserve_rd),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .pending(pending),
        .busy(busy), .ro_violation(ro_violation), .waw_error(waw_error)
    );

    int n_cmp = 0, n_fail = 0;

    typedef struct {
        logic [3:0] rd;
        logic [7:0] data;
    } res_t;

    res_t        q[$];
    logic        m_we, m_ro, m_waw, m_next_alu, m_full, e_ar, e_lr;
    logic [3:0]  m_wa;
    logic [7:0]  m_wd;
    logic [15:0] m_pend;

    typedef struct {
        logic       av;
        logic [3:0] ard;
        logic [7:0] ad;
        logic       lv;
        logic [3:0] lrd;
        logic [7:0] ld;
        logic       rv;
        logic [3:0] rrd;
        logic       ear, elr, ewe;
        logic [3:0] ewa;
        logic [7:0] ewd;
        logic [15:0] epend;
        logic       ebusy, ero;
    } vec_t;

    vec_t tbl[12];

    function automatic vec_t v(int av, int ard, int ad, int lv, int lrd, int ld, int rv, int rrd,
                               int ear, int elr, int ewe, int ewa, int ewd, int epend, int ebusy, int ero);
        vec_t r;
        r.av = 1'(av); r.ard = 4'(ard); r.ad = 8'(ad);
        r.lv = 1'(lv); r.lrd = 4'(lrd); r.ld = 8'(ld);
        r.rv = 1'(rv); r.rrd = 4'(rrd);
        r.ear = 1'(ear); r.elr = 1'(elr); r.ewe = 1'(ewe);
        r.ewa = 4'(ewa); r.ewd = 8'(ewd); r.epend = 16'(epend);
        r.ebusy = 1'(ebusy); r.ero = 1'(ero);
        return r;
    endfunction

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        q.delete();
        m_we = 0; m_wa = 0; m_wd = 0; m_pend = 0;
        m_ro = 0; m_waw = 0; m_next_alu = 0;
    endfunction

    function automatic void predict();
        m_full = q.size() == DEPTH;
        e_ar = reset && alu_valid && !m_full && (!lsu_valid || m_next_alu);
        e_lr = reset && lsu_valid && !m_full && (!alu_valid || !m_next_alu);
    endfunction

    function automatic void model_edge();
        logic [15:0] np;
        res_t e;
        if (!reset) return;
        np = m_pend;
        if (m_we) np[m_wa] = 1'b0;
        if (reserve_valid && int'(reserve_rd) < WR) begin
            if (m_pend[reserve_rd]) m_waw = 1'b1;
            np[reserve_rd] = 1'b1;
        end
        if (q.size() > 0) begin
            e = q.pop_front();
            m_we = 1'b1; m_wa = e.rd; m_wd = e.data;
        end else m_we = 1'b0;
        if (e_ar || e_lr) begin
            e.rd   = e_ar ? alu_rd : lsu_rd;
            e.data = e_ar ? alu_data : lsu_data;
            if (int'(e.rd) >= WR) m_ro = 1'b1;
            else q.push_back(e);
        end
        if (alu_valid && lsu_valid && !m_full) m_next_alu = !m_next_alu;
        m_pend = np;
    endfunction

    task automatic check_outs();
        chk("wr_en", 32'(wr_en), 32'(m_we));
        chk("wr_addr", 32'(wr_addr), 32'(m_wa));
        chk("wr_data", 32'(wr_data), 32'(m_wd));
        chk("pending", 32'(pending), 32'(m_pend));
        chk("busy", 32'(busy), 32'(q.size() > 0 || m_we));
        chk("ro_violation", 32'(ro_violation), 32'(m_ro));
        chk("waw_error", 32'(waw_error), 32'(m_waw));
    endtask

    task automatic step();
        #1;
        predict();
        chk("alu_ready", 32'(alu_ready), 32'(e_ar));
        chk("lsu_ready", 32'(lsu_ready), 32'(e_lr));
        @(posedge clk);
        model_edge();
        #1;
        check_outs();
    endtask

    task automatic idle();
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
        reserve_valid = 0; reserve_rd = 0;
    endtask

    task automatic send_alu(input int rd, input int data);
        alu_valid = 1; alu_rd = 4'(rd); alu_data = 8'(data);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = v(0,0,'h00, 0,0,'h00, 1,3, 0,0, 0,0,'h00, 'h0008, 0,0);
        tbl[1]  = v(1,3,'h5A, 0,0,'h00, 0,0, 1,0, 0,0,'h00, 'h0008, 1,0);
        tbl[2]  = v(0,0,'h00, 0,0,'h00, 0,0, 0,0, 1,3,'h5A, 'h0008, 1,0);
        tbl[3]  = v(0,0,'h00, 0,0,'h00, 0,0, 0,0, 0,0,'h00, 'h0000, 0,0);
        tbl[4]  = v(1,1,'h11, 1,2,'h21, 0,0, 0,1, 0,0,'h00, 'h0000, 1,0);
        tbl[5]  = v(1,1,'h11, 1,2,'h22, 0,0, 1,0, 1,2,'h21, 'h0000, 1,0);
        tbl[6]  = v(1,1,'h12, 1,2,'h22, 0,0, 0,1, 1,1,'h11, 'h0000, 1,0);
        tbl[7]  = v(1,1,'h12, 1,2,'h23, 0,0, 1,0, 1,2,'h22, 'h0000, 1,0);
        tbl[8]  = v(0,0,'h00, 0,0,'h00, 0,0, 0,0, 1,1,'h12, 'h0000, 1,0);
        tbl[9]  = v(0,0,'h00, 0,0,'h00, 0,0, 0,0, 0,0,'h00, 'h0000, 0,0);
        tbl[10] = v(0,0,'h00, 1,14,'hFF, 0,0, 0,1, 0,0,'h00, 'h0000, 0,1);
        tbl[11] = v(0,0,'h00, 0,0,'h00, 0,0, 0,0, 0,0,'h00, 'h0000, 0,1);

        idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outs();
        alu_valid = 1; lsu_valid = 1;
        step();
        idle();
        reset = 1;

        for (int i = 0; i < 12; i++) begin
            alu_valid = tbl[i].av; alu_rd = tbl[i].ard; alu_data = tbl[i].ad;
            lsu_valid = tbl[i].lv; lsu_rd = tbl[i].lrd; lsu_data = tbl[i].ld;
            reserve_valid = tbl[i].rv; reserve_rd = tbl[i].rrd;
            #1;
            chk("tbl_alu_ready", 32'(alu_ready), 32'(tbl[i].ear));
            chk("tbl_lsu_ready", 32'(lsu_ready), 32'(tbl[i].elr));
            step();
            chk("tbl_wr_en", 32'(wr_en), 32'(tbl[i].ewe));
            if (tbl[i].ewe) begin
                chk("tbl_wr_addr", 32'(wr_addr), 32'(tbl[i].ewa));
                chk("tbl_wr_data", 32'(wr_data), 32'(tbl[i].ewd));
            end
            chk("tbl_pending", 32'(pending), 32'(tbl[i].epend));
            chk("tbl_busy", 32'(busy), 32'(tbl[i].ebusy));
            chk("tbl_ro", 32'(ro_violation), 32'(tbl[i].ero));
        end

        // back-to-back LSU stream: every result accepted, written in order one cycle later
        for (int i = 0; i < 7; i++) begin
            idle();
            if (i < 5) begin
                lsu_valid = 1; lsu_rd = 4'(i + 4); lsu_data = 8'('h30 + i);
                #1;
                chk("stream_ready", 32'(lsu_ready), 32'(1));
            end
            step();
            if (i >= 1 && i <= 5) begin
                chk("stream_wr_en", 32'(wr_en), 32'(1));
                chk("stream_addr", 32'(wr_addr), 32'(i + 3));
                chk("stream_data", 32'(wr_data), 32'('h30 + i - 1));
            end
        end

        // WAW hazard, then a reservation landing on the commit edge of the same register
        idle(); reserve_valid = 1; reserve_rd = 2;
        step();
        chk("waw_first", 32'(waw_error), 32'(0));
        step();
        chk("waw_second", 32'(waw_error), 32'(1));
        idle(); send_alu(2, 'h77);
        step();
        idle();
        step();
        chk("commit_wr_en", 32'(wr_en), 32'(1));
        reserve_valid = 1; reserve_rd = 2;
        step();
        chk("set_wins", 32'(pending[2]), 32'(1));
        idle(); send_alu(2, 'h78);
        step();
        idle();
        step();
        step();
        chk("pending2_clear", 32'(pending[2]), 32'(0));

        // asynchronous reset between edges with work in flight
        idle(); reserve_valid = 1; reserve_rd = 5; send_alu(5, 'h99);
        step();
        idle(); lsu_valid = 1; lsu_rd = 7; lsu_data = 8'h42;
        step();
        chk("pre_reset_busy", 32'(busy), 32'(1));
        #2;
        reset = 0;
        #1;
        chk("async_wr_en", 32'(wr_en), 32'(0));
        chk("async_busy", 32'(busy), 32'(0));
        chk("async_pending", 32'(pending), 32'(0));
        chk("async_ro", 32'(ro_violation), 32'(0));
        chk("async_lsu_ready", 32'(lsu_ready), 32'(0));
        model_reset();
        send_alu(1, 'h10);
        step();
        idle();
        reset = 1;
        step();
        send_alu(9, 'h3C);
        step();
        idle();
        step();
        chk("post_reset_wr_en", 32'(wr_en), 32'(1));
        chk("post_reset_addr", 32'(wr_addr), 32'(9));
        chk("post_reset_data", 32'(wr_data), 32'('h3C));
        step();

        // random traffic against the model
        for (int i = 0; i < 600; i++) begin
            alu_valid = 1'($urandom_range(0, 1));
            alu_rd = 4'($urandom_range(0, 15));
            alu_data = 8'($urandom);
            lsu_valid = 1'($urandom_range(0, 1));
            lsu_rd = 4'($urandom_range(0, 15));
            lsu_data = 8'($urandom);
            reserve_valid = $urandom_range(0, 3) == 0;
            reserve_rd = 4'($urandom_range(0, 15));
            step();
        end
        idle();
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
